// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Oversampled UART transmitter. Sends start bit, DBIT data
//                bits LSB-first, an optional even-parity bit and a stop bit of
//                SB_TICK ticks. Bit timing comes from a 16x s_tick strobe.
//                Optional feature macro: UART_TX_PARITY_EN (parity bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    output logic            tx_ready,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int               c_BCW            = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BIT       = c_BCW'(DBIT - 1);
    localparam logic [4:0]       c_BIT_LAST_TICK  = 5'd15;
    localparam logic [4:0]       c_STOP_LAST_TICK = 5'(SB_TICK - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_tick;
    logic [4:0]       w_tick_next;
    logic [c_BCW-1:0] r_bit;
    logic [c_BCW-1:0] w_bit_next;
    logic [DBIT-1:0]  r_shift;
    logic [DBIT-1:0]  w_shift_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_done;
`ifdef UART_TX_PARITY_EN
    logic             r_par;
    logic             w_par_next;
`endif

    // State, counters, shift register and the registered serial line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    // Next-state logic; the line level is derived from the next state so that
    // every bit change lands on the edge that follows the qualifying tick.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_done       = 1'b0;
        w_tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif

        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_state_next = S_START;
                    w_tick_next  = '0;
                    w_bit_next   = '0;
                    w_shift_next = tx_din;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken from the word as latched, since the
                    // shift register is consumed while sending.
                    w_par_next   = ^tx_din;
`endif
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (r_tick == c_BIT_LAST_TICK) begin
                        w_state_next = S_DATA;
                        w_tick_next  = '0;
                    end else begin
                        w_tick_next  = r_tick + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (r_tick == c_BIT_LAST_TICK) begin
                        w_tick_next  = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_bit == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end else begin
                            w_bit_next   = r_bit + 1'b1;
                        end
                    end else begin
                        w_tick_next  = r_tick + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (r_tick == c_BIT_LAST_TICK) begin
                        w_state_next = S_STOP;
                        w_tick_next  = '0;
                    end else begin
                        w_tick_next  = r_tick + 5'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (r_tick == c_STOP_LAST_TICK) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                        w_tick_next  = '0;
                    end else begin
                        w_tick_next  = r_tick + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_par_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign tx_ready     = (r_state == S_IDLE);
    assign tx_done_tick = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (SB_TICK=16 and SB_TICK=32
//                instances). Expected line levels come from a frame model
//                indexed by the number of ticks seen since accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic       tx_start32 = 1'b0;
    logic [7:0] tx_din = 8'h00;

    logic tx_ready, tx_done_tick, tx;
    logic tx_ready32, tx_done_tick32, tx32;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
        .tx_din(tx_din), .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx(tx)
    );

    uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start32),
        .tx_din(tx_din), .tx_ready(tx_ready32), .tx_done_tick(tx_done_tick32), .tx(tx32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         sel;
        bit         junk;
        bit         b2b;
        int         exp_len;
    } vec_t;

    vec_t tbl[8];

    // Frame model: level of the line after k ticks since accept.
    function automatic logic model_bit(input logic [7:0] d, input int k);
        int idx;
        logic [7:0] dd;
        idx = k / 16;
        dd  = d;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return dd[idx-1];
        if (PBITS == 1 && idx == 9) return ^dd;
        return 1'b1;
    endfunction

    function automatic int frame_len(input int sb);
        return 16 * (1 + 8 + PBITS) + sb;
    endfunction

    function automatic logic [2:0] sample(input bit sel);
        return sel ? {tx32, tx_ready32, tx_done_tick32} : {tx, tx_ready, tx_done_tick};
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {tx,ready,done} got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) tx_start32 = v;
        else     tx_start   = v;
    endtask

    // Entered and left at posedge+1 of a cycle in which the selected DUT idles.
    task automatic send_frame(input logic [7:0] d, input int period, input bit sel,
                              input bit junk, input bit b2b, input int total,
                              input string tag);
        int   k;
        int   cyc;
        int   budget;
        logic expd;
        set_start(sel, 1'b1);
        tx_din = d;
        s_tick = 1'($urandom_range(0, 1));
        #4;
        chk($sformatf("%s_accept", tag), sample(sel), 3'b110);
        @(posedge clk); #1;
        k      = 0;
        cyc    = 0;
        budget = total * period + 64;
        while (k < total && cyc < budget) begin
            set_start(sel, 1'b0);
            tx_din = 8'($urandom);
            s_tick = ((cyc % period) == (period - 1));
            if (junk && cyc == 40) begin
                set_start(sel, 1'b1);
                tx_din = 8'hFF;
            end
            expd = s_tick && (k == total - 1);
            if (b2b && expd) begin
                set_start(sel, 1'b1);
                tx_din = 8'($urandom);
            end
            #4;
            chk($sformatf("%s_k%0d", tag, k), sample(sel), {model_bit(d, k), 1'b0, expd});
            if (s_tick) k++;
            cyc++;
            @(posedge clk); #1;
        end
        set_start(sel, 1'b0);
        s_tick = 1'b0;
        if (k < total) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: ticks seen %0d required %0d", tag, k, total);
        end
        chk($sformatf("%s_post", tag), sample(sel), 3'b110);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h55, 4, 1'b0, 1'b0, 1'b0, 160 + 16 * PBITS};
        tbl[1] = '{8'hA3, 4, 1'b0, 1'b1, 1'b0, 160 + 16 * PBITS};
        tbl[2] = '{8'h3C, 3, 1'b0, 1'b0, 1'b1, 160 + 16 * PBITS};
        tbl[3] = '{8'h0F, 1, 1'b0, 1'b0, 1'b0, 160 + 16 * PBITS};
        tbl[4] = '{8'h07, 2, 1'b0, 1'b0, 1'b0, 160 + 16 * PBITS};
        tbl[5] = '{8'h03, 5, 1'b0, 1'b0, 1'b0, 160 + 16 * PBITS};
        tbl[6] = '{8'h00, 4, 1'b1, 1'b0, 1'b0, 176 + 16 * PBITS};
        tbl[7] = '{8'hFF, 1, 1'b1, 1'b1, 1'b0, 176 + 16 * PBITS};

        // Power-on reset values.
        #1 reset = 1'b1;
        #2;
        chk("reset_dut16", sample(1'b0), 3'b110);
        chk("reset_dut32", sample(1'b1), 3'b110);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset while idle.
        #2 reset = 1'b1;
        #1 chk("reset_idle", sample(1'b0), 3'b110);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the middle of the data phase of a 0x00 frame.
        tx_start = 1'b1;
        tx_din   = 8'h00;
        s_tick   = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("mid_data_line", sample(1'b0), 3'b000);
        #2 reset = 1'b1;
        #1 chk("reset_mid_data", sample(1'b0), 3'b110);
        @(posedge clk); #1;
        reset  = 1'b0;
        s_tick = 1'b0;
        send_frame(8'h5A, 2, 1'b0, 1'b0, 1'b0, frame_len(16), "after_reset");

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].period, tbl[i].sel, tbl[i].junk,
                       tbl[i].b2b, tbl[i].exp_len, $sformatf("vec%0d", i));
        end

        // Randomized frames against the model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            int         p;
            bit         sel;
            d   = 8'($urandom);
            p   = $urandom_range(1, 4);
            sel = 1'($urandom_range(0, 1));
            send_frame(d, p, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       frame_len(sel ? 32 : 16), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that pairs with the existing oversampled receiver on the RSA/RFID link. Accepts a parallel word via a single-cycle start strobe and shifts it out LSB-first as start bit, data bits, optional parity bit and stop bit. Bit timing is derived from the shared 16× oversampling `s_tick` from the baud generator, so one bit lasts 16 ticks.

## Interface
- `DBIT`, 8: number of data bits per frame (1–16).
- `SB_TICK`, 16: stop-bit length in `s_tick` pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `s_tick` input 1: one-cycle oversampling tick, 16 per bit period.
- `tx_start` input 1: one-cycle request to send `tx_din`.
- `tx_din` input DBIT: word to transmit; sampled only on accept.
- `tx_ready` output 1: high in idle; request is accepted only when high.
- `tx_done_tick` output 1: one-cycle pulse at the end of the stop bit.
- `tx` output 1: serial line, registered, idles high.

## Operation
- States: `idle`, `start`, `data`, `parity` (present only with the macro), `stop`.
- `idle`: `tx` = 1, `tx_ready` = 1. If `tx_start` = 1, the block latches `tx_din` into its shift register, clears the tick and bit counters, and moves to `start`.
- `start`: `tx` = 0. Counts `s_tick`. On the 16th tick (counter = 15), it clears the counter and moves to `data`.
- `data`: `tx` = shift register bit 0. On the 16th tick, the shift register shifts right and the counter is cleared. After bit `DBIT-1`, the block moves to `parity` if enabled, otherwise to `stop`. Bit counter width is `$clog2(DBIT)`, with a minimum of 1.
- `parity`: `tx` = even parity (XOR of all latched data bits). Lasts 16 ticks, then moves to `stop`.
- `stop`: `tx` = 1. On tick count `SB_TICK-1`, the block asserts `tx_done_tick` for that cycle and returns to `idle`.
- `tx_start` outside `idle` is ignored: no queuing and no corruption of the frame in flight.
- Changes on `tx_din` after accept have no effect on the current frame.
- Tick counter is 5 bits wide so that `SB_TICK` values up to 32 are legal.

## Timing
- Reset values: `tx` = 1, `tx_ready` = 1, `tx_done_tick` = 0, state = `idle`, all counters and the shift register = 0.
- Accept latency: `tx` falls on the clock edge that samples `tx_start` = 1 in `idle`. `tx_ready` falls on the same edge.
- An `s_tick` coincident with the accepting cycle is not counted. Counting starts with the first tick after the accept.
- Frame length in ticks: 16 × (1 + DBIT [+1 with parity]) + SB_TICK.
- `tx_done_tick` is high in the last cycle of `stop`, which is combinational from the state and the tick. `tx_ready` rises on the next edge.
- A `tx_start` asserted in the `tx_done_tick` cycle is ignored. The earliest back-to-back accept is the following cycle, so there is no idle gap on `tx` beyond one clock.
- Each bit transition on `tx` occurs on the clock edge after the qualifying `s_tick`.
- Reset asserted mid-frame immediately (asynchronously) forces `tx` = 1 and returns the block to `idle`. No `tx_done_tick` is produced.
- `s_tick` held high continuously is legal: each cycle counts as one tick.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the `parity` state is compiled in and an even-parity bit is inserted between the data and stop bits.
  - Undefined: the `parity` state and the parity XOR logic are absent, and `data` transitions directly to `stop`.
- The receiver must be built with the matching setting.

## Test plan
- Reset check: assert `reset` mid-idle and mid-data of a frame → `tx` = 1 asynchronously, `tx_ready` = 1, no `tx_done_tick`. A new frame is then sent correctly.
- Basic frame (DBIT=8, SB_TICK=16, `s_tick` every 4 clocks): send 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each held 16 ticks. `tx_done_tick` pulses once, 160 ticks after accept.
- Ignored request: pulse `tx_start` with 0xFF while sending 0xA3 → the line carries only 0xA3 (bits 1,1,0,0,0,1,0,1), and `tx_ready` stays 0 until done.
- Back-to-back: assert `tx_start` in the done cycle (ignored), then on the next cycle with 0x0F → the stop bit is followed by a start bit within 1 clock, and the second frame is correct.
- Parity (macro defined): send 0x07 → parity bit 1. Send 0x03 → parity bit 0. Frame length is 176 ticks.
- Stop length: SB_TICK=32, send 0x00 → stop high for 32 ticks, and `tx_done_tick` arrives at tick 176.
